load_from_mm: RTL and testbench

Main-memory load engine for the multicycle CPU: the read-side counterpart of the store path. On a 4-phase enable/acknowledge handshake from the control FSM it:
- issues a word read to the on-chip synchronous RAM;
- waits a fixed read latency;
- captures the returned word into a stable result register for the register-file write-back;
- flags out-of-range addresses without touching memory.

---
 rtl/mm_pkg.sv | 16 +
 rtl/load_from_mm.sv | 116 +++++++++++
 tb/tb_load_from_mm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared main-memory definitions for the load and store paths.
// State encoding is common to both engines.
package mm_pkg;

    localparam int MM_ADDR_W       = 11;
    localparam int MM_READ_LATENCY = 2;
    localparam int MM_WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/load_from_mm.sv
// Main-memory load engine: enable/acknowledge handshake, one word
// read from synchronous RAM, result held stable for write-back.
module load_from_mm
    import mm_pkg::*;
#(
    parameter int ADDR_W       = MM_ADDR_W,
    parameter int READ_LATENCY = MM_READ_LATENCY
) (
    input  logic                 CLOCK_50,
    input  logic                 resetIn,
    input  logic                 enable,
    output logic                 acknowledge,
    input  logic [MM_WORD_W-1:0] ADDout,
    output logic [MM_WORD_W-1:0] RD,
    output logic                 addrError,
    output logic [ADDR_W-1:0]    address,
    output logic                 readEnable,
    input  logic [MM_WORD_W-1:0] dataRead
);

    // WAIT lasts READ_LATENCY cycles, so the counter starts one below.
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    state_t               state, state_n;
    logic [2:0]           cnt, cnt_n;
    logic                 err_q, err_n_q;
    logic [ADDR_W-1:0]    addr_n;
    logic [MM_WORD_W-1:0] rd_n;
    logic                 aerr_n;
    logic                 re_n;
    logic                 ack_n;
    logic                 hi_err;

    // Any set bit above the memory word range is an out-of-range access.
    assign hi_err = |ADDout[MM_WORD_W-1:ADDR_W];

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n_q = err_q;
        addr_n  = address;
        rd_n    = RD;
        aerr_n  = addrError;
        re_n    = readEnable;
        ack_n   = acknowledge;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = ISSUE;
                    addr_n  = ADDout[ADDR_W-1:0];
                    err_n_q = hi_err;
                    re_n    = ~hi_err;
                end
            end
            ISSUE: begin
                if (err_q) begin
                    state_n = DONE;
                    rd_n    = '0;
                    aerr_n  = 1'b1;
                    ack_n   = 1'b1;
                    re_n    = 1'b0;
                end else begin
                    state_n = WAIT;
                    cnt_n   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_n = DONE;
                    rd_n    = dataRead;
                    aerr_n  = 1'b0;
                    ack_n   = 1'b1;
                    re_n    = 1'b0;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                ack_n   = 1'b0;
                re_n    = 1'b0;
            end
        endcase
    end

    // State, latency counter and all registered outputs.
    always_ff @(posedge CLOCK_50 or posedge resetIn) begin
        if (resetIn) begin
            state       <= IDLE;
            cnt         <= '0;
            err_q       <= 1'b0;
            address     <= '0;
            RD          <= '0;
            addrError   <= 1'b0;
            readEnable  <= 1'b0;
            acknowledge <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            err_q       <= err_n_q;
            address     <= addr_n;
            RD          <= rd_n;
            addrError   <= aerr_n;
            readEnable  <= re_n;
            acknowledge <= ack_n;
        end
    end

endmodule

// File: tb/tb_load_from_mm.sv
// Directed bench for load_from_mm at latency 2 and latency 1,
// with a behavioural synchronous RAM per instance.
module tb_load_from_mm;

    logic        clk;
    logic        rst;

    logic        en0, ack0, err0, re0;
    logic [31:0] add0, rd0, dr0;
    logic [10:0] adr0;

    logic        en1, ack1, err1, re1;
    logic [31:0] add1, rd1, dr1;
    logic [10:0] adr1;

    logic [31:0] mem [0:2047];
    logic [31:0] p0 [0:1];
    logic [31:0] q1;

    int ncmp = 0;
    int nerr = 0;
    int recnt;

    load_from_mm #(.ADDR_W(11), .READ_LATENCY(2)) dut0 (
        .CLOCK_50(clk), .resetIn(rst), .enable(en0),
        .acknowledge(ack0), .ADDout(add0), .RD(rd0),
        .addrError(err0), .address(adr0),
        .readEnable(re0), .dataRead(dr0)
    );

    load_from_mm #(.ADDR_W(11), .READ_LATENCY(1)) dut1 (
        .CLOCK_50(clk), .resetIn(rst), .enable(en1),
        .acknowledge(ack1), .ADDout(add1), .RD(rd1),
        .addrError(err1), .address(adr1),
        .readEnable(re1), .dataRead(dr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with two-edge read latency for dut0
    always @(posedge clk) begin
        if (re0) p0[0] <= mem[adr0];
        p0[1] <= p0[0];
    end
    assign dr0 = p0[1];

    // RAM with one-edge read latency for dut1
    always @(posedge clk) begin
        if (re1) q1 <= mem[adr1];
    end
    assign dr1 = q1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h005] = 32'hDEADBEEF;
        mem[11'h7FF] = 32'h12345678;
        mem[11'h001] = 32'h0BADF00D;
        mem[11'h002] = 32'hCAFEF00D;
        mem[11'h010] = 32'hA5A5A5A5;
        p0[0] = '0; p0[1] = '0; q1 = '0;
        rst = 1'b1;
        en0 = 0; add0 = '0;
        en1 = 0; add1 = '0;
        step(); step();
        chk("rst_ack", {31'd0, ack0}, 32'd0);
        chk("rst_re", {31'd0, re0}, 32'd0);
        chk("rst_rd", rd0, 32'd0);
        chk("rst_adr", {21'd0, adr0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        rst = 1'b0;

        // word load at latency 2
        en0 = 1; add0 = 32'h5;
        step();
        chk("wl_adr_e0", {21'd0, adr0}, 32'h5);
        chk("wl_re_e0", {31'd0, re0}, 32'd1);
        step();
        chk("wl_ack_e1", {31'd0, ack0}, 32'd0);
        step();
        chk("wl_ack_e2", {31'd0, ack0}, 32'd0);
        chk("wl_re_e2", {31'd0, re0}, 32'd1);
        step();
        chk("wl_ack_e3", {31'd0, ack0}, 32'd1);
        chk("wl_rd", rd0, 32'hDEADBEEF);
        chk("wl_err", {31'd0, err0}, 32'd0);
        chk("wl_re_e3", {31'd0, re0}, 32'd0);
        en0 = 0;
        step();
        chk("wl_rel_ack", {31'd0, ack0}, 32'd0);
        chk("wl_rel_rd", rd0, 32'hDEADBEEF);

        // out-of-range address
        en0 = 1; add0 = 32'h800;
        step();
        chk("oor_re_e0", {31'd0, re0}, 32'd0);
        chk("oor_ack_e0", {31'd0, ack0}, 32'd0);
        step();
        chk("oor_ack_e1", {31'd0, ack0}, 32'd1);
        chk("oor_rd", rd0, 32'd0);
        chk("oor_err", {31'd0, err0}, 32'd1);
        chk("oor_re_e1", {31'd0, re0}, 32'd0);
        en0 = 0;
        step();
        chk("oor_rel", {31'd0, ack0}, 32'd0);

        // early release: one-cycle enable
        en0 = 1; add0 = 32'h7FF;
        step();
        en0 = 0; add0 = 32'h5;
        step();
        chk("er_ack_e1", {31'd0, ack0}, 32'd0);
        step();
        chk("er_ack_e2", {31'd0, ack0}, 32'd0);
        step();
        chk("er_ack_e3", {31'd0, ack0}, 32'd1);
        chk("er_rd", rd0, 32'h12345678);
        step();
        chk("er_ack_e4", {31'd0, ack0}, 32'd0);
        step();
        chk("er_rd_idle", rd0, 32'h12345678);
        chk("er_adr_idle", {21'd0, adr0}, 32'h7FF);

        // held enable: one burst only
        en0 = 1; add0 = 32'h2;
        recnt = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (re0) recnt++;
            if (i == 4) add0 = 32'h5;
        end
        chk("he_re_cnt", recnt, 32'd3);
        chk("he_ack", {31'd0, ack0}, 32'd1);
        chk("he_rd", rd0, 32'hCAFEF00D);
        chk("he_adr", {21'd0, adr0}, 32'h2);
        en0 = 0;
        step();
        chk("he_rel", {31'd0, ack0}, 32'd0);
        en0 = 1;
        step();
        chk("he_retrig_re", {31'd0, re0}, 32'd1);
        chk("he_retrig_adr", {21'd0, adr0}, 32'h5);
        step(); step(); step();
        chk("he_retrig_rd", rd0, 32'hDEADBEEF);
        en0 = 0;
        step();

        // asynchronous reset during WAIT
        en0 = 1; add0 = 32'h7FF;
        step(); step(); step();
        en0 = 0;
        #2 rst = 1'b1;
        #1;
        chk("ar_ack", {31'd0, ack0}, 32'd0);
        chk("ar_re", {31'd0, re0}, 32'd0);
        chk("ar_adr", {21'd0, adr0}, 32'd0);
        chk("ar_rd", rd0, 32'd0);
        #1 rst = 1'b0;
        en0 = 1; add0 = 32'h1;
        step();
        chk("ar_new_adr", {21'd0, adr0}, 32'h1);
        step(); step(); step();
        chk("ar_new_ack", {31'd0, ack0}, 32'd1);
        chk("ar_new_rd", rd0, 32'h0BADF00D);
        en0 = 0;
        step();

        // latency-1 instance
        en1 = 1; add1 = 32'h10;
        step();
        chk("l1_re_e0", {31'd0, re1}, 32'd1);
        step();
        chk("l1_ack_e1", {31'd0, ack1}, 32'd0);
        step();
        chk("l1_ack_e2", {31'd0, ack1}, 32'd1);
        chk("l1_rd", rd1, 32'hA5A5A5A5);
        en1 = 0;
        step();
        chk("l1_rel", {31'd0, ack1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
